register_file_mp: RTL and testbench

- Parametrised multi-port register file for the next pipelined core: NRD read ports, NWR write ports, configurable width and depth.
- Adds an optional same-cycle write-to-read bypass and a per-register busy scoreboard, used by decode for hazard detection.
- Adds a registered write-conflict flag.
- Sits between decode (reads, claims) and writeback (writes); register 0 is hardwired to zero.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 41 ++++
 rtl/register_file_mp.sv | 111 +++++++++++
 tb/tb_register_file_mp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
// AW is derived from the default depth; instances with other depths derive their own.
package rf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = $clog2(NREGS);

    typedef logic [AW-1:0]     regsel_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for decode hazard detection.
// A later step overrides an earlier one: write-clear, then flush, then claim.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = rf_pkg::NREGS,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NREGS-1:0] wr_vec,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_sel,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q & ~wr_vec;
        if (flush) begin
            busy_d = '0;
        end
        if (claim_en && (claim_sel != '0)) begin
            busy_d[claim_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write-to-read bypass, busy scoreboard
// and a registered write-conflict flag. Register 0 reads as zero and ignores writes.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned NREGS  = rf_pkg::NREGS,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_sel,
    input  logic                  flush,
    output logic                  conflict_err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NWR-1:0]    weff;
    logic [NREGS-1:0]  wr_vec;
    logic [NREGS-1:0]  busy;
    logic              conflict_q;
    logic              conflict_d;

    logic [AW-1:0]     rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;

    // Ascending port order makes the highest-indexed enabled port win.
    always_comb begin
        regs_d     = regs_q;
        wr_vec     = '0;
        conflict_d = 1'b0;
        weff       = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            weff[j] = wen[j] && (wsel[j*AW +: AW] != '0);
        end
        for (int unsigned j = 0; j < NWR; j++) begin
            if (weff[j]) begin
                regs_d[wsel[j*AW +: AW]] = wdat[j*DATA_W +: DATA_W];
                wr_vec[wsel[j*AW +: AW]] = 1'b1;
                for (int unsigned k = j + 1; k < NWR; k++) begin
                    if (weff[k] && (wsel[k*AW +: AW] == wsel[j*AW +: AW])) begin
                        conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        rdat    = '0;
        rbusy   = '0;
        rd_sel  = '0;
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_sel  = rsel[i*AW +: AW];
            rd_data = regs_q[rd_sel];
            rd_hit  = 1'b0;
            if (BYPASS) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (weff[j] && (wsel[j*AW +: AW] == rd_sel)) begin
                        rd_data = wdat[j*DATA_W +: DATA_W];
                        rd_hit  = 1'b1;
                    end
                end
            end
            rdat[i*DATA_W +: DATA_W] = rd_data;
            rbusy[i]                 = busy[rd_sel] & ~rd_hit;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .nrst      (nrst),
        .wr_vec    (wr_vec),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .flush     (flush),
        .busy      (busy)
    );

    assign conflict_err = conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed checks of register_file_mp with bypass enabled and disabled side by side.
module tb_register_file_mp;
    import rf_pkg::*;

    logic        clk;
    logic        nrst;
    logic [9:0]  rsel;
    logic [1:0]  wen;
    logic [9:0]  wsel;
    logic [63:0] wdat;
    logic        claim_en;
    logic [4:0]  claim_sel;
    logic        flush;

    logic [63:0] rdat_b,  rdat_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic        conf_b,  conf_n;

    int n_tests = 0;
    int n_fail  = 0;

    register_file_mp #(
        .DATA_W (32), .NREGS (32), .NRD (2), .NWR (2), .BYPASS (1'b1)
    ) u_dut (
        .clk (clk), .nrst (nrst), .rsel (rsel), .rdat (rdat_b), .rbusy (rbusy_b),
        .wen (wen), .wsel (wsel), .wdat (wdat), .claim_en (claim_en),
        .claim_sel (claim_sel), .flush (flush), .conflict_err (conf_b)
    );

    register_file_mp #(
        .DATA_W (32), .NREGS (32), .NRD (2), .NWR (2), .BYPASS (1'b0)
    ) u_dut_nb (
        .clk (clk), .nrst (nrst), .rsel (rsel), .rdat (rdat_n), .rbusy (rbusy_n),
        .wen (wen), .wsel (wsel), .wdat (wdat), .claim_en (claim_en),
        .claim_sel (claim_sel), .flush (flush), .conflict_err (conf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen       = '0;
        wsel      = '0;
        wdat      = '0;
        claim_en  = 1'b0;
        claim_sel = '0;
        flush     = 1'b0;
    endtask

    task automatic set_w(input int unsigned p, input regsel_t s, input word_t d);
        wen[p]         = 1'b1;
        wsel[p*5 +: 5] = s;
        wdat[p*32 +: 32] = d;
    endtask

    task automatic set_r(input regsel_t s0, input regsel_t s1);
        rsel = {s1, s0};
    endtask

    task automatic claim(input regsel_t s);
        claim_en  = 1'b1;
        claim_sel = s;
    endtask

    initial begin
        nrst = 1'b0;
        rsel = '0;
        idle();
        #1;
        chk("reset_rdat_b",  rdat_b[31:0], 32'h0);
        chk("reset_rbusy_b", {30'd0, rbusy_b}, 32'h0);
        chk("reset_conf_b",  {31'd0, conf_b}, 32'h0);
        chk("reset_conf_n",  {31'd0, conf_n}, 32'h0);
        #11 nrst = 1'b1;

        // Plain write then read back
        step();
        set_w(0, 5'd5, 32'hDEADBEEF);
        step();
        idle();
        set_r(5'd5, 5'd0);
        #1;
        chk("rd_r5_b", rdat_b[31:0], 32'hDEADBEEF);
        chk("rd_r5_n", rdat_n[31:0], 32'hDEADBEEF);

        // Register 0 ignores writes, even via bypass
        step();
        set_w(0, 5'd0, 32'h1);
        set_r(5'd0, 5'd0);
        #1;
        chk("r0_bypass_b", rdat_b[31:0], 32'h0);
        step();
        idle();
        #1;
        chk("r0_after_b", rdat_b[31:0], 32'h0);
        chk("r0_after_n", rdat_n[31:0], 32'h0);
        chk("r0_rbusy_b", {30'd0, rbusy_b}, 32'h0);

        // Same-cycle bypass on port 1
        step();
        set_w(1, 5'd7, 32'hCAFE);
        set_r(5'd0, 5'd7);
        #1;
        chk("byp_r7_b", rdat_b[63:32], 32'hCAFE);
        chk("byp_r7_n", rdat_n[63:32], 32'h0);
        step();
        idle();
        #1;
        chk("r7_next_n", rdat_n[63:32], 32'hCAFE);
        chk("r7_next_b", rdat_b[63:32], 32'hCAFE);

        // Write conflict: highest port wins, flag pulses one cycle
        step();
        set_w(0, 5'd3, 32'hAAAA);
        set_w(1, 5'd3, 32'hBBBB);
        set_r(5'd3, 5'd0);
        #1;
        chk("conf_pre_b", {31'd0, conf_b}, 32'h0);
        chk("byp_conf_b", rdat_b[31:0], 32'hBBBB);
        step();
        idle();
        #1;
        chk("conf_set_b", {31'd0, conf_b}, 32'h1);
        chk("conf_set_n", {31'd0, conf_n}, 32'h1);
        chk("r3_win_n",   rdat_n[31:0], 32'hBBBB);
        step();
        #1;
        chk("conf_clr_b", {31'd0, conf_b}, 32'h0);
        set_w(0, 5'd0, 32'h1111);
        set_w(1, 5'd0, 32'h2222);
        step();
        idle();
        #1;
        chk("conf_r0_b", {31'd0, conf_b}, 32'h0);
        chk("r3_keep_b", rdat_b[31:0], 32'hBBBB);

        // Scoreboard lifecycle on r9
        step();
        claim(5'd9);
        set_r(5'd9, 5'd0);
        #1;
        chk("claim_same_b", {31'd0, rbusy_b[0]}, 32'h0);
        step();
        idle();
        #1;
        chk("busy9_b", {31'd0, rbusy_b[0]}, 32'h1);
        chk("busy9_n", {31'd0, rbusy_n[0]}, 32'h1);
        set_w(0, 5'd9, 32'h99);
        #1;
        chk("busy9_wr_b", {31'd0, rbusy_b[0]}, 32'h0);
        chk("busy9_wr_n", {31'd0, rbusy_n[0]}, 32'h1);
        step();
        idle();
        #1;
        chk("busy9_clr_b", {31'd0, rbusy_b[0]}, 32'h0);
        chk("busy9_clr_n", {31'd0, rbusy_n[0]}, 32'h0);
        chk("r9_data_n",   rdat_n[31:0], 32'h99);
        step();
        claim(5'd9);
        set_w(0, 5'd9, 32'h100);
        step();
        idle();
        #1;
        chk("claim_wr_b", {31'd0, rbusy_b[0]}, 32'h1);
        chk("claim_wr_n", {31'd0, rbusy_n[0]}, 32'h1);

        // Flush with simultaneous claim
        claim(5'd4);
        step();
        claim(5'd6);
        step();
        claim(5'd8);
        step();
        idle();
        set_r(5'd6, 5'd8);
        #1;
        chk("busy6_pre", {30'd0, rbusy_n}, 32'h3);
        flush = 1'b1;
        claim(5'd10);
        step();
        idle();
        set_r(5'd4, 5'd10);
        #1;
        chk("flush_4_10", {30'd0, rbusy_b}, 32'h2);
        set_r(5'd6, 5'd8);
        #1;
        chk("flush_6_8", {30'd0, rbusy_b}, 32'h0);
        set_r(5'd9, 5'd0);
        #1;
        chk("flush_9", {30'd0, rbusy_n}, 32'h0);

        // Asynchronous reset mid-operation
        step();
        claim(5'd4);
        step();
        idle();
        set_w(0, 5'd12, 32'h55);
        step();
        idle();
        set_r(5'd4, 5'd12);
        #1;
        chk("pre_rst_busy", {31'd0, rbusy_b[0]}, 32'h1);
        chk("pre_rst_r12",  rdat_n[63:32], 32'h55);
        set_w(0, 5'd13, 32'h77);
        claim(5'd13);
        nrst = 1'b0;
        #1;
        chk("rst_busy4_b", {31'd0, rbusy_b[0]}, 32'h0);
        chk("rst_busy4_n", {31'd0, rbusy_n[0]}, 32'h0);
        chk("rst_r12_b",   rdat_b[63:32], 32'h0);
        chk("rst_r12_n",   rdat_n[63:32], 32'h0);
        step();
        idle();
        @(negedge clk);
        nrst = 1'b1;
        set_r(5'd13, 5'd3);
        #1;
        chk("rst_r13_n",    rdat_n[31:0], 32'h0);
        chk("rst_busy13_n", {31'd0, rbusy_n[0]}, 32'h0);
        chk("rst_r3_b",     rdat_b[63:32], 32'h0);
        set_r(5'd5, 5'd7);
        #1;
        chk("rst_r5_b", rdat_b[31:0], 32'h0);
        chk("rst_r7_n", rdat_n[63:32], 32'h0);
        chk("rst_conf", {31'd0, conf_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
